key_event_ctrl: RTL and testbench

//  N-channel pushbutton conditioner for the game controller, replacing raw op_keys wiring.
//  Per channel: synchroniser, debounce and press detection, plus optional auto-repeat.

---
 rtl/key_event_ctrl_pkg.sv | 22 ++
 rtl/key_event_ctrl_debounce.sv | 64 ++++++
 rtl/key_event_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_ctrl_pkg.sv
// Shared constants and types for the pushbutton event controller.
package key_event_ctrl_pkg;

  // Channel assignment on the game controller
  localparam int KEY_UP    = 32'sd0;
  localparam int KEY_DOWN  = 32'sd1;
  localparam int KEY_LEFT  = 32'sd2;
  localparam int KEY_RIGHT = 32'sd3;

  // Default timing at 25 MHz: 10 ms debounce, 300 ms first repeat, 100 ms repeat rate
  localparam int DEF_DEBOUNCE_CYC    = 32'sd250000;
  localparam int DEF_REPEAT_DLY_CYC  = 32'sd7500000;
  localparam int DEF_REPEAT_RATE_CYC = 32'sd2500000;

  // Auto-repeat state per channel
  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_WAIT = 2'd1,
    RPT_RUN  = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_event_ctrl_debounce.sv
// One key channel: two-flop synchroniser, debounce counter and press/release strobes.
// The strobes are combinational and coincide with the edge on which key_level changes.
module key_debounce
  import key_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic press,
  output logic fall
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  // Raw level of a released button; sync flops start here so a held key is not seen during reset
  localparam logic          REL_LVL  = ACTIVE_LOW;

  logic          sync1_r;
  logic          sync2_r;
  logic          synced_s;
  logic          level_r;
  logic          accept_s;
  logic [CW-1:0] cnt_r;

  // Polarity is normalised after the sync stage: 1 means pressed
  assign synced_s  = sync2_r ^ ACTIVE_LOW;
  assign accept_s  = (synced_s != level_r) && (cnt_r == CNT_LAST);
  assign press     = accept_s & ~level_r;
  assign fall      = accept_s & level_r;
  assign key_level = level_r;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= REL_LVL;
      sync2_r <= REL_LVL;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive differing samples; accept the new level after DEBOUNCE_CYC of them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (synced_s == level_r) begin
      cnt_r   <= '0;
      level_r <= level_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      level_r <= ~level_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      level_r <= level_r;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// N-channel pushbutton conditioner: debounced levels plus a queue of press/auto-repeat
// events delivered one at a time over a valid/ready port.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int                N_KEYS          = 4,
  parameter int                DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
  parameter int                REPEAT_DLY_CYC  = DEF_REPEAT_DLY_CYC,
  parameter int                REPEAT_RATE_CYC = DEF_REPEAT_RATE_CYC,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(4'b1110),
  parameter bit                ACTIVE_LOW      = 1'b0,
  localparam int               KW              = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KW-1:0]     evt_key,
  output logic              evt_repeat,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  localparam int            TMAX      = (REPEAT_DLY_CYC > REPEAT_RATE_CYC) ? REPEAT_DLY_CYC : REPEAT_RATE_CYC;
  localparam int            TW        = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DLY_LOAD  = TW'(REPEAT_DLY_CYC - 1);
  localparam logic [TW-1:0] RATE_LOAD = TW'(REPEAT_RATE_CYC - 1);

  logic [N_KEYS-1:0] press_s;
  logic [N_KEYS-1:0] fall_s;
  logic [N_KEYS-1:0] rpt_evt_s;
  logic [N_KEYS-1:0] new_evt_s;
  logic [N_KEYS-1:0] pend_r;
  logic [N_KEYS-1:0] pend_n;
  logic [N_KEYS-1:0] rep_r;
  logic [N_KEYS-1:0] rep_n;
  logic [N_KEYS-1:0] grant_vec_s;
  logic [KW-1:0]     grant_idx_s;
  logic              any_pend_s;
  logic              load_s;
  logic              ovf_hit_s;

  rpt_state_e        state_r [N_KEYS];
  rpt_state_e        state_n [N_KEYS];
  logic [TW-1:0]     timer_r [N_KEYS];
  logic [TW-1:0]     timer_n [N_KEYS];

  // Lowest set bit wins the output slot
  function automatic logic [KW-1:0] lowest_idx(input logic [N_KEYS-1:0] v);
    logic [KW-1:0] idx;
    idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KW'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_debounce (
      .clk       (vga_clk),
      .rst_n     (rst_n),
      .key_raw   (key_raw[g]),
      .key_level (key_level[g]),
      .press     (press_s[g]),
      .fall      (fall_s[g])
    );
  end

  // Repeat FSMs: a release always wins, otherwise count down and emit a repeat at zero
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_n[i]   = state_r[i];
      timer_n[i]   = timer_r[i];
      rpt_evt_s[i] = 1'b0;
      if (fall_s[i]) begin
        state_n[i] = RPT_IDLE;
        timer_n[i] = '0;
      end else begin
        case (state_r[i])
          RPT_IDLE: begin
            if (press_s[i] && REPEAT_MASK[i]) begin
              state_n[i] = RPT_WAIT;
              timer_n[i] = DLY_LOAD;
            end else begin
              state_n[i] = RPT_IDLE;
            end
          end
          RPT_WAIT, RPT_RUN: begin
            if (timer_r[i] == '0) begin
              rpt_evt_s[i] = 1'b1;
              state_n[i]   = RPT_RUN;
              timer_n[i]   = RATE_LOAD;
            end else begin
              timer_n[i]   = timer_r[i] - TW'(1);
            end
          end
          default: begin
            state_n[i] = RPT_IDLE;
            timer_n[i] = '0;
          end
        endcase
      end
    end
  end

  // Repeat state and timer registers
  always_ff @(posedge vga_clk) begin
    for (int i = 0; i < N_KEYS; i++) begin
      if (!rst_n) begin
        state_r[i] <= RPT_IDLE;
        timer_r[i] <= '0;
      end else begin
        state_r[i] <= state_n[i];
        timer_r[i] <= timer_n[i];
      end
    end
  end

  // A press can only occur in IDLE, so press and repeat never coincide on one channel
  assign new_evt_s   = press_s | rpt_evt_s;
  assign any_pend_s  = |pend_r;
  assign load_s      = ~evt_valid | evt_ready;
  assign grant_idx_s = lowest_idx(pend_r);

  // One-hot grant of the channel moving into the output slot this cycle
  always_comb begin
    grant_vec_s = '0;
    if (load_s && any_pend_s) begin
      grant_vec_s[grant_idx_s] = 1'b1;
    end else begin
      grant_vec_s = '0;
    end
  end

  // Pending bits: a new event overwrites an ungranted one and flags the loss
  always_comb begin
    pend_n    = pend_r;
    rep_n     = rep_r;
    ovf_hit_s = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (new_evt_s[i]) begin
        pend_n[i] = 1'b1;
        rep_n[i]  = rpt_evt_s[i];
        if (pend_r[i] && !grant_vec_s[i]) ovf_hit_s = 1'b1;
        else                              ovf_hit_s = ovf_hit_s;
      end else if (grant_vec_s[i]) begin
        pend_n[i] = 1'b0;
      end else begin
        pend_n[i] = pend_r[i];
      end
    end
  end

  // Pending event registers
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      pend_r <= '0;
      rep_r  <= '0;
    end else begin
      pend_r <= pend_n;
      rep_r  <= rep_n;
    end
  end

  // Output slot: refill when empty or when the current event is being accepted
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      evt_valid  <= 1'b0;
      evt_key    <= '0;
      evt_repeat <= 1'b0;
    end else if (load_s) begin
      if (any_pend_s) begin
        evt_valid  <= 1'b1;
        evt_key    <= grant_idx_s;
        evt_repeat <= rep_r[grant_idx_s];
      end else begin
        evt_valid  <= 1'b0;
        evt_key    <= evt_key;
        evt_repeat <= evt_repeat;
      end
    end else begin
      evt_valid  <= evt_valid;
      evt_key    <= evt_key;
      evt_repeat <= evt_repeat;
    end
  end

  // Sticky overflow flag; a new loss beats a simultaneous clear
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      evt_ovf <= 1'b0;
    end else if (ovf_hit_s) begin
      evt_ovf <= 1'b1;
    end else if (ovf_clr) begin
      evt_ovf <= 1'b0;
    end else begin
      evt_ovf <= evt_ovf;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomised bench for key_event_ctrl with a cycle-level reference model and event scoreboard.
module tb_key_event_ctrl;

  localparam int         N    = 4;
  localparam int         D    = 4;
  localparam int         DLY  = 20;
  localparam int         RATE = 8;
  localparam logic [3:0] MASK = 4'b1110;

  logic       vga_clk   = 1'b0;
  logic       rst_n     = 1'b0;
  logic [3:0] key_raw   = 4'b0000;
  logic       evt_ready = 1'b1;
  logic       ovf_clr   = 1'b0;
  logic [3:0] key_level;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic       evt_repeat;
  logic       evt_ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int key;
    bit rep;
  } evt_t;
  evt_t exp_q[$];

  // Reference model state
  longint     cyc = 0;
  logic [3:0] m_s1 = 4'b0000, m_s2 = 4'b0000, m_level = 4'b0000;
  logic [3:0] m_pend = 4'b0000, m_rep = 4'b0000;
  int         m_run [4];
  bit         m_armed [4];
  longint     m_next [4];
  bit         m_valid = 1'b0, m_rep_out = 1'b0, m_ovf = 1'b0;
  int         m_key = 0;

  always #5 vga_clk = ~vga_clk;

  key_event_ctrl #(
    .N_KEYS          (N),
    .DEBOUNCE_CYC    (D),
    .REPEAT_DLY_CYC  (DLY),
    .REPEAT_RATE_CYC (RATE),
    .REPEAT_MASK     (MASK),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_key    (evt_key),
    .evt_repeat (evt_repeat),
    .evt_ovf    (evt_ovf),
    .ovf_clr    (ovf_clr)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model of one clock edge, using the inputs as they stand at that edge
  task automatic model_step();
    logic [3:0] ev, evrep, old_rep;
    logic       load, any, toggled;
    bit         ovf_hit;
    int         g;
    cyc++;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_rep = '0;
      m_valid = 1'b0; m_key = 0; m_rep_out = 1'b0; m_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_armed[i] = 1'b0; m_next[i] = 0;
      end
      exp_q.delete();
      return;
    end
    ev = '0; evrep = '0;
    for (int i = 0; i < N; i++) begin
      toggled = 1'b0;
      // level is accepted after D consecutive synchronised samples disagree with it
      if (m_s2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_run[i] = 0; m_level[i] = ~m_level[i]; toggled = 1'b1;
          if (m_level[i]) begin
            ev[i] = 1'b1; m_armed[i] = MASK[i]; m_next[i] = cyc + DLY;
          end else begin
            m_armed[i] = 1'b0;
          end
        end
      end else begin
        m_run[i] = 0;
      end
      // repeats fall at press+DLY, then every RATE cycles while held
      if (!toggled && m_level[i] && m_armed[i] && cyc == m_next[i]) begin
        ev[i] = 1'b1; evrep[i] = 1'b1; m_next[i] = m_next[i] + RATE;
      end
    end
    any = |m_pend;
    g = 0;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) g = i;
    load = !m_valid || evt_ready;
    old_rep = m_rep;
    ovf_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ev[i]) begin
        if (m_pend[i] && !(load && any && g == i)) ovf_hit = 1'b1;
        m_pend[i] = 1'b1; m_rep[i] = evrep[i];
      end else if (load && any && g == i) begin
        m_pend[i] = 1'b0;
      end
    end
    if (load) begin
      if (any) begin
        m_valid = 1'b1; m_key = g; m_rep_out = old_rep[g];
        exp_q.push_back('{key: g, rep: old_rep[g]});
      end else begin
        m_valid = 1'b0;
      end
    end
    if (ovf_hit) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_s2 = m_s1; m_s1 = key_raw;
  endtask

  // Advance one clock; inputs may be changed by the caller once this returns
  task automatic cycle();
    @(posedge vga_clk);
    model_step();
    #2;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Monitor: compare outputs each cycle and pop the scoreboard on each handshake
  initial begin
    evt_t e;
    forever begin
      @(negedge vga_clk);
      chk("key_level", key_level, m_level);
      chk("evt_valid", evt_valid, m_valid);
      chk("evt_ovf", evt_ovf, m_ovf);
      if (evt_valid && m_valid) begin
        chk("evt_key", evt_key, m_key);
        chk("evt_repeat", evt_repeat, m_rep_out);
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected: got event key %0d rep %0d, expected no event", evt_key, evt_repeat);
        end else begin
          e = exp_q.pop_front();
          chk("sb_key", evt_key, e.key);
          chk("sb_rep", evt_repeat, e.rep);
        end
      end
    end
  end

  int lat;
  int hold_cnt [4];

  initial begin
    // Reset state
    wait_cycles(3);
    chk("rst_key_level", key_level, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_key", evt_key, 0);
    chk("rst_evt_repeat", evt_repeat, 0);
    chk("rst_evt_ovf", evt_ovf, 0);
    rst_n = 1'b1;
    wait_cycles(3);

    // Clean press on key 2: level after exactly 2+D edges
    key_raw[2] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (key_level[2] && lat == 0) lat = n;
    end
    chk("press_latency", lat, 2 + D);
    key_raw[2] = 1'b0;
    wait_cycles(15);

    // Bounce on key 1 never reaches the debounce threshold
    for (int k = 0; k < 15; k++) begin
      key_raw[1] = ~key_raw[1];
      wait_cycles(2);
    end
    key_raw[1] = 1'b0;
    wait_cycles(15);
    chk("bounce_level", key_level[1], 0);

    // Hold key 3 (repeats), then key 0 (no repeat)
    key_raw[3] = 1'b1;
    wait_cycles(66);
    key_raw[3] = 1'b0;
    wait_cycles(30);
    key_raw[0] = 1'b1;
    wait_cycles(40);
    key_raw[0] = 1'b0;
    wait_cycles(15);

    // Keys 0 and 3 together
    key_raw = 4'b1001;
    wait_cycles(10);
    key_raw = 4'b0000;
    wait_cycles(15);

    // Stalled consumer with key 1 repeating
    evt_ready = 1'b0;
    key_raw[1] = 1'b1;
    wait_cycles(40);
    key_raw[1] = 1'b0;
    wait_cycles(10);
    chk("ovf_set", evt_ovf, 1);
    evt_ready = 1'b1;
    wait_cycles(5);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("ovf_clr", evt_ovf, 0);
    wait_cycles(5);

    // Reset with an event presented and another pending; keys held through reset
    evt_ready = 1'b0;
    key_raw = 4'b1100;
    wait_cycles(10);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_key", evt_key, 0);
    chk("mid_rst_level", key_level, 0);
    rst_n = 1'b1;
    key_raw = 4'b0000;
    wait_cycles(20);
    evt_ready = 1'b1;
    wait_cycles(5);

    // Randomised phase
    for (int i = 0; i < N; i++) hold_cnt[i] = 0;
    for (int rc = 0; rc < 2500; rc++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_cnt[i] == 0) begin
          key_raw[i] = ~key_raw[i];
          hold_cnt[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
        end else begin
          hold_cnt[i]--;
        end
      end
      evt_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 49) == 0);
      rst_n     = !(rc >= 1200 && rc < 1202);
      cycle();
    end

    // Drain
    rst_n = 1'b1;
    key_raw = 4'b0000;
    evt_ready = 1'b1;
    ovf_clr = 1'b0;
    wait_cycles(120);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
